control_unit_fsm: RTL and testbench



---
 rtl/control_unit_pkg.sv | 61 ++++++
 rtl/mem_wait_timer.sv | 31 +++
 rtl/control_unit_fsm.sv | 201 ++++++++++++++++++++
 tb/tb_control_unit_fsm.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_unit_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, RV32I opcodes and the
// datapath mux select values used by both the sequencer and the datapath.
package control_unit_pkg;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5,
    StTrap   = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    ClsIllegal = 2'd0,
    ClsExec    = 2'd1,
    ClsMem     = 2'd2
  } insn_cls_e;

  localparam logic [6:0] OpcLoad    = 7'b0000011;
  localparam logic [6:0] OpcMiscMem = 7'b0001111;
  localparam logic [6:0] OpcOpImm   = 7'b0010011;
  localparam logic [6:0] OpcAuipc   = 7'b0010111;
  localparam logic [6:0] OpcStore   = 7'b0100011;
  localparam logic [6:0] OpcOp      = 7'b0110011;
  localparam logic [6:0] OpcLui     = 7'b0110111;
  localparam logic [6:0] OpcBranch  = 7'b1100011;
  localparam logic [6:0] OpcJalr    = 7'b1100111;
  localparam logic [6:0] OpcJal     = 7'b1101111;
  localparam logic [6:0] OpcSystem  = 7'b1110011;

  localparam logic       AddrAlu  = 1'b0;
  localparam logic       AddrPc   = 1'b1;

  localparam logic [1:0] RdAlu    = 2'b00;
  localparam logic [1:0] RdMem    = 2'b01;
  localparam logic [1:0] RdCsr    = 2'b10;

  localparam logic [1:0] Alu1Rs   = 2'b00;
  localparam logic [1:0] Alu1Pc   = 2'b01;
  localparam logic [1:0] Alu1Zero = 2'b10;

  localparam logic [1:0] Alu2Rs   = 2'b00;
  localparam logic [1:0] Alu2Imm  = 2'b01;
  localparam logic [1:0] Alu2Is   = 2'b10;

  // SYSTEM with funct3 == 0 (ECALL/EBREAK/xRET) is not supported and traps.
  function automatic insn_cls_e decode_class(input logic [6:0] opc, input logic f3_nz);
    insn_cls_e cls;
    case (opc)
      OpcLoad, OpcStore:                     cls = ClsMem;
      OpcOp, OpcOpImm, OpcLui, OpcAuipc,
      OpcJal, OpcJalr, OpcBranch, OpcMiscMem: cls = ClsExec;
      OpcSystem:                             cls = f3_nz ? ClsExec : ClsIllegal;
      default:                               cls = ClsIllegal;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory-wait watchdog: counts cycles spent waiting on the bus; expired flags the
// MEM_TIMEOUT-th cycle of the current wait (entry cycle counts as the first).
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(MEM_TIMEOUT - 1);
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MEM_TIMEOUT);

  logic [CntW-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != MaxCnt)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired = enable && (count_q == LastCnt);

endmodule

// File: rtl/control_unit_fsm.sv
// Multicycle instruction sequencer with memory-wait watchdog and sticky trap.
// Define CONTROL_UNIT_FSM__DEBUG_EN to build the debug HALT/resume path.
module control_unit_fsm
  import control_unit_pkg::*;
#(
  parameter int unsigned OPCODE_WIDTH = 7,
  parameter int unsigned F3_WIDTH     = 3,
  parameter int unsigned MEM_TIMEOUT  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [F3_WIDTH-1:0]     f3,
  input  logic                    mem_complete,
  input  logic                    halt_req,
  input  logic                    resume_req,
  output logic                    write_pc,
  output logic                    write_ir,
  output logic                    write_rd,
  output logic                    write_csr,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic                    load_op,
  output logic                    addr_sel,
  output logic [1:0]              rd_sel,
  output logic [1:0]              alu_insel1,
  output logic [1:0]              alu_insel2,
  output logic                    trap,
  output logic                    halted
);

  state_e     state_q, state_d;
  logic [6:0] opc;
  logic       timer_clear, timer_en, timer_expired;
  logic       halt_take;

  assign opc = 7'(opcode);

  assign timer_en    = (state_q == StFetch) || (state_q == StMem);
  assign timer_clear = (state_d != state_q);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (timer_en),
    .expired(timer_expired)
  );

`ifdef CONTROL_UNIT_FSM__DEBUG_EN
  logic fetch_entry_q;

  // Halt is only honoured on the first FETCH cycle so no bus access is left in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_entry_q <= 1'b1;
    end else begin
      fetch_entry_q <= (state_d == StFetch) && (state_q != StFetch);
    end
  end

  assign halt_take = (state_q == StFetch) && fetch_entry_q && halt_req;
`else
  logic unused_debug;
  assign unused_debug = halt_req ^ resume_req;
  assign halt_take    = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    write_pc   = 1'b0;
    write_ir   = 1'b0;
    write_rd   = 1'b0;
    write_csr  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    load_op    = 1'b0;
    addr_sel   = AddrAlu;
    rd_sel     = RdAlu;
    alu_insel1 = Alu1Rs;
    alu_insel2 = Alu2Rs;
    trap       = 1'b0;
    halted     = 1'b0;

    // Outputs are forced low for the whole time reset is asserted.
    if (!rst) begin
      unique case (state_q)
        StFetch: begin
          if (halt_take) begin
            state_d = StHalt;
          end else begin
            addr_sel = AddrPc;
            mem_read = 1'b1;
            if (mem_complete) begin
              write_ir = 1'b1;
              state_d  = StDecode;
            end else if (timer_expired) begin
              state_d = StTrap;
            end
          end
        end

        StDecode: begin
          unique case (decode_class(opc, |f3))
            ClsMem:  state_d = StMem;
            ClsExec: state_d = StExec;
            default: state_d = StTrap;
          endcase
        end

        StExec: begin
          write_pc = 1'b1;
          state_d  = StFetch;
          case (opc)
            OpcOp: write_rd = 1'b1;
            OpcOpImm: begin
              write_rd   = 1'b1;
              alu_insel2 = Alu2Imm;
            end
            OpcLui: begin
              write_rd   = 1'b1;
              alu_insel1 = Alu1Zero;
              alu_insel2 = Alu2Imm;
            end
            OpcAuipc: begin
              write_rd   = 1'b1;
              alu_insel1 = Alu1Pc;
              alu_insel2 = Alu2Imm;
            end
            OpcJal, OpcJalr: begin
              write_rd   = 1'b1;
              alu_insel1 = Alu1Pc;
              alu_insel2 = Alu2Is;
            end
            OpcSystem: begin
              rd_sel    = RdCsr;
              write_rd  = 1'b1;
              write_csr = 1'b1;
            end
            default: ;
          endcase
        end

        StMem: begin
          addr_sel   = AddrAlu;
          alu_insel1 = Alu1Rs;
          alu_insel2 = Alu2Imm;
          if (opc == OpcLoad) begin
            mem_read = 1'b1;
            load_op  = 1'b1;
          end else begin
            mem_write = 1'b1;
          end
          // A completion in the watchdog's final cycle still counts.
          if (mem_complete) begin
            if (opc == OpcLoad) begin
              state_d = StWb;
            end else begin
              write_pc = 1'b1;
              state_d  = StFetch;
            end
          end else if (timer_expired) begin
            state_d = StTrap;
          end
        end

        StWb: begin
          rd_sel   = RdMem;
          write_rd = 1'b1;
          write_pc = 1'b1;
          load_op  = 1'b1;
          state_d  = StFetch;
        end

`ifdef CONTROL_UNIT_FSM__DEBUG_EN
        StHalt: begin
          halted = 1'b1;
          if (resume_req) begin
            state_d = StFetch;
          end
        end
`endif

        StTrap: trap = 1'b1;

        default: state_d = StTrap;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_control_unit_fsm.sv
// Scoreboard bench: a per-instruction reference model expands each instruction into its
// expected per-cycle outputs; a negedge monitor pops and compares every cycle.
module tb_control_unit_fsm;

  localparam int unsigned T = 4;

  localparam logic [6:0] LOAD    = 7'b0000011;
  localparam logic [6:0] MISCMEM = 7'b0001111;
  localparam logic [6:0] OPIMM   = 7'b0010011;
  localparam logic [6:0] AUIPC   = 7'b0010111;
  localparam logic [6:0] STORE   = 7'b0100011;
  localparam logic [6:0] OP      = 7'b0110011;
  localparam logic [6:0] LUI     = 7'b0110111;
  localparam logic [6:0] BRANCH  = 7'b1100011;
  localparam logic [6:0] JALR    = 7'b1100111;
  localparam logic [6:0] JAL     = 7'b1101111;
  localparam logic [6:0] SYSTEM  = 7'b1110011;

  localparam int KAny    = 0;
  localparam int KEntry  = 1;
  localparam int KHalt   = 2;
  localparam int KStay   = 3;
  localparam int KResume = 4;

  typedef struct packed {
    logic       wpc, wir, wrd, wcsr, mrd, mwr, ld, asel;
    logic [1:0] rds, a1, a2;
    logic       tr, hl;
  } out_t;

  typedef struct {
    logic       r;
    logic       mc;
    int         kind;
    logic [6:0] opc;
    logic [2:0] f3;
    out_t       exp;
  } cyc_t;

  logic       clk, rst, mem_complete, halt_req, resume_req;
  logic [6:0] opcode;
  logic [2:0] f3;
  logic       write_pc, write_ir, write_rd, write_csr, mem_read, mem_write, load_op, addr_sel;
  logic [1:0] rd_sel, alu_insel1, alu_insel2;
  logic       trap, halted;

  cyc_t       plan[$];
  out_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc_no = 0;
  logic [6:0] cur_opc = '0;
  logic [2:0] cur_f3 = '0;

  control_unit_fsm #(
    .OPCODE_WIDTH(7),
    .F3_WIDTH    (3),
    .MEM_TIMEOUT (T)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .f3          (f3),
    .mem_complete(mem_complete),
    .halt_req    (halt_req),
    .resume_req  (resume_req),
    .write_pc    (write_pc),
    .write_ir    (write_ir),
    .write_rd    (write_rd),
    .write_csr   (write_csr),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .load_op     (load_op),
    .addr_sel    (addr_sel),
    .rd_sel      (rd_sel),
    .alu_insel1  (alu_insel1),
    .alu_insel2  (alu_insel2),
    .trap        (trap),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  function automatic void add(input logic r, input logic mc, input int kind, input out_t e);
    cyc_t c;
    c.r    = r;
    c.mc   = mc;
    c.kind = kind;
    c.opc  = cur_opc;
    c.f3   = cur_f3;
    c.exp  = e;
    plan.push_back(c);
  endfunction

  function automatic void add_rst(input int n);
    for (int i = 0; i < n; i++) add(1'b1, rbit(), KAny, '0);
  endfunction

  // Trap is sticky: hold it for 20 cycles with stray completions, then reset.
  function automatic void trap_tail();
    out_t e = '0;
    e.tr = 1'b1;
    for (int i = 0; i < 20; i++) add(1'b0, rbit(), KAny, e);
    add_rst(2);
  endfunction

  function automatic bit is_exec(input logic [6:0] opc, input logic [2:0] fv);
    return opc inside {OP, OPIMM, LUI, AUIPC, JAL, JALR, BRANCH, MISCMEM} ||
           (opc == SYSTEM && fv != 3'd0);
  endfunction

  function automatic out_t exec_exp(input logic [6:0] opc);
    out_t e = '0;
    e.wpc = 1'b1;
    case (opc)
      OP:          e.wrd = 1'b1;
      OPIMM:       begin e.wrd = 1'b1; e.a2 = 2'b01; end
      LUI:         begin e.wrd = 1'b1; e.a1 = 2'b10; e.a2 = 2'b01; end
      AUIPC:       begin e.wrd = 1'b1; e.a1 = 2'b01; e.a2 = 2'b01; end
      JAL, JALR:   begin e.wrd = 1'b1; e.a1 = 2'b01; e.a2 = 2'b10; end
      SYSTEM:      begin e.wrd = 1'b1; e.wcsr = 1'b1; e.rds = 2'b10; end
      default:     ;
    endcase
    return e;
  endfunction

  // fw/mw = wait cycles before mem_complete; >= T means it never arrives.
  function automatic void build_instr(input logic [6:0] opc, input logic [2:0] fv, input int fw,
                                      input int mw, input bit abort_mem);
    out_t e;
    bit   load = (opc == LOAD);
    for (int c = 0; c < int'(T); c++) begin
      cur_opc = 7'($urandom);
      cur_f3  = 3'($urandom);
      e = '0;
      e.asel = 1'b1;
      e.mrd  = 1'b1;
      if (c == fw) begin
        e.wir = 1'b1;
        add(1'b0, 1'b1, (c == 0) ? KEntry : KAny, e);
        break;
      end
      add(1'b0, 1'b0, (c == 0) ? KEntry : KAny, e);
    end
    if (fw >= int'(T)) begin
      trap_tail();
      return;
    end
    cur_opc = opc;
    cur_f3  = fv;
    add(1'b0, rbit(), KAny, '0);
    if (is_exec(opc, fv)) begin
      add(1'b0, rbit(), KAny, exec_exp(opc));
    end else if (opc == LOAD || opc == STORE) begin
      for (int c = 0; c < int'(T); c++) begin
        e = '0;
        e.a2 = 2'b01;
        if (load) begin e.mrd = 1'b1; e.ld = 1'b1; end
        else      e.mwr = 1'b1;
        if (abort_mem && c == 2) begin
          add_rst(2);
          return;
        end
        if (c == mw) begin
          e.wpc = !load;
          add(1'b0, 1'b1, KAny, e);
          break;
        end
        add(1'b0, 1'b0, KAny, e);
      end
      if (mw >= int'(T)) begin
        trap_tail();
        return;
      end
      if (load) begin
        e = '0;
        e.rds = 2'b01;
        e.wrd = 1'b1;
        e.wpc = 1'b1;
        e.ld  = 1'b1;
        add(1'b0, rbit(), KAny, e);
      end
    end else begin
      trap_tail();
    end
  endfunction

  // Halt at a FETCH entry, park for n cycles, then resume (with halt_req still high).
  function automatic void build_halt(input int n);
    out_t e = '0;
    add(1'b0, 1'b0, KHalt, e);
    e.hl = 1'b1;
    for (int i = 1; i < n; i++) add(1'b0, 1'b0, KStay, e);
    add(1'b0, 1'b0, KResume, e);
  endfunction

  always @(negedge clk) begin : monitor
    out_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {write_pc, write_ir, write_rd, write_csr, mem_read, mem_write, load_op, addr_sel,
           rd_sel, alu_insel1, alu_insel2, trap, halted};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs cycle %0d: got %h expected %h (wpc,wir,wrd,wcsr,mrd,mwr,ld,asel,rds,a1,a2,trap,halted)",
                 cyc_no, a, e);
      end
      if (rst === 1'b1) begin
        checks++;
        if (a !== '0) begin
          errors++;
          $display("FAIL reset state cycle %0d: outputs %h not all zero", cyc_no, a);
        end
      end
      checks++;
      if (trap !== e.tr) begin
        errors++;
        $display("FAIL trap cycle %0d: got %b expected %b", cyc_no, trap, e.tr);
      end
      cyc_no++;
    end
  end

  initial begin
    logic [6:0] ops[13];
    int idx, fw, mw;
    rst          = 1'b1;
    mem_complete = 1'b0;
    halt_req     = 1'b0;
    resume_req   = 1'b0;
    opcode       = '0;
    f3           = '0;
    ops = '{OP, OPIMM, LUI, AUIPC, JAL, JALR, BRANCH, MISCMEM, SYSTEM, LOAD, STORE,
            7'b0000000, 7'b1111111};

    add_rst(2);
    build_instr(OPIMM, 3'd0, 0, 0, 1'b0);
    build_instr(LOAD, 3'd2, 0, 2, 1'b0);
    build_instr(STORE, 3'd2, 1, 0, 1'b0);
    build_instr(OP, 3'd0, 0, 0, 1'b0);
    build_instr(LUI, 3'd0, 0, 0, 1'b0);
    build_instr(AUIPC, 3'd0, 0, 0, 1'b0);
    build_instr(JAL, 3'd0, 0, 0, 1'b0);
    build_instr(JALR, 3'd0, 0, 0, 1'b0);
    build_instr(BRANCH, 3'd1, 0, 0, 1'b0);
    build_instr(MISCMEM, 3'd0, 0, 0, 1'b0);
    build_instr(SYSTEM, 3'd1, 0, 0, 1'b0);
    build_instr(OP, 3'd0, T - 1, 0, 1'b0);
    build_instr(LOAD, 3'd2, 0, T - 1, 1'b0);
    build_instr(STORE, 3'd2, 0, T - 1, 1'b0);
    build_instr(STORE, 3'd2, 0, T, 1'b1);
    build_instr(OPIMM, 3'd0, 0, 0, 1'b0);
    build_instr(7'b0000000, 3'd0, 0, 0, 1'b0);
    build_instr(SYSTEM, 3'd0, 0, 0, 1'b0);
    build_instr(OP, 3'd0, T, 0, 1'b0);
    build_instr(LOAD, 3'd2, 0, T, 1'b0);
    build_instr(STORE, 3'd2, 0, T, 1'b0);
`ifdef CONTROL_UNIT_FSM__DEBUG_EN
    build_halt(1);
    build_instr(OPIMM, 3'd0, 0, 0, 1'b0);
    build_halt(3);
    build_instr(LOAD, 3'd2, 1, 1, 1'b0);
`endif

    for (int n = 0; n < 80; n++) begin
      idx = $urandom_range(0, 12);
      fw  = ($urandom_range(0, 19) == 0) ? int'(T) : int'($urandom_range(0, T - 1));
      mw  = ($urandom_range(0, 19) == 0) ? int'(T) : int'($urandom_range(0, T - 1));
`ifdef CONTROL_UNIT_FSM__DEBUG_EN
      if ($urandom_range(0, 7) == 0) build_halt(int'($urandom_range(1, 3)));
`endif
      build_instr(ops[idx], 3'($urandom), fw, mw, 1'b0);
    end

    foreach (plan[i]) begin
      @(posedge clk);
      #1;
      rst          = plan[i].r;
      mem_complete = plan[i].mc;
      opcode       = plan[i].opc;
      f3           = plan[i].f3;
      case (plan[i].kind)
        KHalt:   begin halt_req = 1'b1;   resume_req = 1'b0; end
        KStay:   begin halt_req = rbit(); resume_req = 1'b0; end
        KResume: begin halt_req = 1'b1;   resume_req = 1'b1; end
        KEntry: begin
`ifdef CONTROL_UNIT_FSM__DEBUG_EN
          halt_req = 1'b0;
`else
          halt_req = rbit();
`endif
          resume_req = rbit();
        end
        default: begin halt_req = rbit(); resume_req = rbit(); end
      endcase
      exp_q.push_back(plan[i].exp);
    end

    @(posedge clk);
    #1;
    mem_complete = 1'b0;
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
